// File: rtl/display_pkg.sv
// Shared types and constants for the display write arbiter: FSM states,
// requester indices and default address widths.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    PEND = 2'd2
  } arb_state_e;

  localparam int REQ_SPI    = 0;
  localparam int REQ_RENDER = 1;

  localparam int DEF_ROWS    = 8;
  localparam int DEF_COLUMNS = 32;

  // Address width for a given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ROW_W = addr_w(DEF_ROWS);
  localparam int COL_W = addr_w(DEF_COLUMNS);

endpackage

// File: rtl/display_write_arbiter_rr.sv
// Two-input round-robin picker: on a tie the requester that did not win
// last time is chosen. Output is one-hot, or zero when nobody requests.
module rr_arbiter2
  import display_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_pick
);

  always_comb begin
    o_pick = 2'b00;
    case (i_req)
      2'b01:   o_pick[REQ_SPI]    = 1'b1;
      2'b10:   o_pick[REQ_RENDER] = 1'b1;
      2'b11: begin
        if (i_last) o_pick[REQ_SPI]    = 1'b1;
        else        o_pick[REQ_RENDER] = 1'b1;
      end
      default: o_pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/display_write_arbiter.sv
// Frame-level owner of the display-memory write port and buffer flip.
// Optional ownership watchdog is built when ARB_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | no owner; arbitrate on any req
//   OWN   | one producer owns the back buffer and its writes pass through
//   PEND  | frame loaded; waiting for frame_complete to flip buffers
module display_write_arbiter
  import display_pkg::*;
#(
  parameter  int rows           = DEF_ROWS,
  parameter  int columns        = DEF_COLUMNS,
  parameter  int width          = 48,
  parameter  int timeout_cycles = 1048576,
  localparam int RW             = addr_w(rows),
  localparam int CW             = addr_w(columns)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_done,
  input  logic [1:0]        i_wen,
  input  logic [2*RW-1:0]   i_wrow,
  input  logic [2*CW-1:0]   i_wcol,
  input  logic [2*width-1:0] i_wdata,
  input  logic              i_frame_complete,
  output logic [1:0]        o_gnt,
  output logic              o_m_wen,
  output logic [RW-1:0]     o_m_wrow,
  output logic [CW-1:0]     o_m_wcol,
  output logic [width-1:0]  o_m_wdata,
  output logic              o_mem_flip,
  output logic              o_busy,
  output logic [7:0]        o_frame_count,
  output logic              o_timeout
);

  arb_state_e r_state;
  logic [1:0] r_gnt;
  logic       r_owner;
  logic       r_last;
  logic       r_flip;
  logic [7:0] r_frame_count;
  logic [1:0] w_pick;
  logic       w_own;
  logic       w_owner_wen;
  logic       w_wd_expire;

  rr_arbiter2 u_rr (
    .i_req  (i_req),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  assign w_own       = (r_state == OWN);
  assign w_owner_wen = i_wen[r_owner];

  assign o_m_wen   = w_own & w_owner_wen;
  assign o_m_wrow  = !w_own ? '0 : (r_owner ? i_wrow[2*RW-1:RW] : i_wrow[RW-1:0]);
  assign o_m_wcol  = !w_own ? '0 : (r_owner ? i_wcol[2*CW-1:CW] : i_wcol[CW-1:0]);
  assign o_m_wdata = !w_own ? '0 : (r_owner ? i_wdata[2*width-1:width] : i_wdata[width-1:0]);

  assign o_gnt         = r_gnt;
  assign o_mem_flip    = r_flip;
  assign o_busy        = (r_state != IDLE);
  assign o_frame_count = r_frame_count;

`ifdef ARB_TIMEOUT_EN
  localparam int WDW = $clog2(timeout_cycles + 1);
  logic [WDW-1:0] r_wd_cnt;
  logic           r_timeout;

  // Idle cycles since grant or the owner's last write.
  assign w_wd_expire = w_own && !w_owner_wen && (r_wd_cnt == WDW'(timeout_cycles - 1));
  assign o_timeout   = r_timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == IDLE || !w_own || w_owner_wen || w_wd_expire) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_timeout <= 1'b0;
    else       r_timeout <= w_wd_expire && !i_done[r_owner] && i_req[r_owner];
  end
`else
  // Watchdog limit is only meaningful when the watchdog is built.
  localparam bit WD_PRESENT = (timeout_cycles < 0);
  assign w_wd_expire = WD_PRESENT;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_gnt         <= 2'b00;
      r_owner       <= 1'b0;
      r_last        <= 1'b1;
      r_flip        <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_gnt   <= w_pick;
            r_owner <= w_pick[REQ_RENDER];
            r_state <= OWN;
          end
        end
        OWN: begin
          if (i_done[r_owner]) begin
            r_gnt   <= 2'b00;
            r_state <= PEND;
          end else if (!i_req[r_owner]) begin
            r_gnt   <= 2'b00;
            r_state <= IDLE;
          end else if (w_wd_expire) begin
            r_gnt   <= 2'b00;
            r_last  <= r_owner;
            r_state <= IDLE;
          end
        end
        PEND: begin
          if (i_frame_complete) begin
            r_flip        <= ~r_flip;
            r_frame_count <= r_frame_count + 8'd1;
            r_last        <= r_owner;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/display_write_arbiter.md
Name: display_write_arbiter

Overview:
- Owns the write port and buffer-flip control of the double-buffered display memory. Shares that port between two frame producers: requester 0 (SPI loader) and requester 1 (on-chip clock-face renderer).
- Grants one producer exclusive ownership of the back buffer for a whole frame. After that producer signals done, waits for the driver's frame_complete, then toggles the flip signal.
- Replaces the ad-hoc ready/flip logic at top level; sits between the producers and display_memory.

Parameters:
- rows, 8, display rows per segment; wrow width is $clog2(rows).
- columns, 32, display columns; wcol width is $clog2(columns).
- width, 48, pixel word width (bitdepth*3*segments).
- timeout_cycles, 1048576, ownership watchdog limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  2  per-requester request for a frame of back-buffer ownership (level).
- done  in  2  per-requester frame-loaded pulse; sampled only from the owner.
- wen_i  in  2  per-requester write enable.
- wrow_i  in  2*$clog2(rows)  per-requester row address, requester 0 in the low slice.
- wcol_i  in  2*$clog2(columns)  per-requester column address.
- wdata_i  in  2*width  per-requester pixel data.
- frame_complete  in  1  pulse from display driver at end of a scanned frame.
- gnt  out  2  one-hot ownership grant (registered).
- m_wen  out  1  memory write enable.
- m_wrow  out  $clog2(rows)  memory write row.
- m_wcol  out  $clog2(columns)  memory write column.
- m_wdata  out  width  memory write data.
- mem_flip  out  1  buffer-select toggle to display_memory.
- busy  out  1  high when state != IDLE.
- frame_count  out  8  completed flips; wraps 255 -> 0.
- timeout  out  1  one-cycle watchdog abort pulse.

Behaviour:
- Reset: state=IDLE, gnt=00, mem_flip=0, frame_count=0, timeout=0, last=1 (requester 0 wins the first tie). m_wen=0; m_wrow, m_wcol and m_wdata read 0 while gnt=00.
- States: IDLE, OWN, PEND.
- IDLE:
  - Any req bit set at cycle N -> gnt one-hot at N+1, state OWN. Latency is 1 cycle.
  - Single requester: it is granted.
  - Both requesting: round-robin; grant the index != last.
- OWN:
  - Mux is combinational from the owner: m_wen = wen_i[owner], plus its address and data.
  - The non-owner's wen_i is ignored; no writes are dropped from the owner.
  - done[owner] -> state PEND, gnt=00 next cycle. The write coincident with done is still passed through.
  - req[owner] low without done -> abort to IDLE, gnt=00, no flip; back-buffer contents are undefined.
  - done from the non-owner is ignored.
- PEND:
  - m_wen=0.
  - frame_complete -> mem_flip toggles, frame_count+1, last=owner, state IDLE, all on the next edge.
  - A frame_complete in the same cycle as done is not honoured; the flip waits for the next frame_complete seen in PEND.
  - req is ignored in PEND.
- Simultaneous events:
  - Re-arbitration can occur no earlier than the cycle after returning to IDLE.
  - A requester holding req continuously is re-granted only if the other is idle.
- rst mid-operation forces the reset values on the next edge, including mem_flip=0. The front buffer reverts to buffer 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and on every owner wen_i. It increments each cycle in OWN.
  - On reaching timeout_cycles: abort to IDLE, gnt=00, timeout pulses high for 1 cycle, no flip, last=owner.
- Undefined: no counter is built; timeout is tied 0.

Decomposition:
- Shared package display_pkg holds:
  - the state enum (IDLE/OWN/PEND);
  - the requester index constants REQ_SPI=0, REQ_RENDER=1;
  - localparams for the address widths derived from rows/columns.
- One natural sub-module, rr_arbiter2: 2-input round-robin picker with a last-grant input, returning a one-hot pick.

Test Plan:
- After reset, pulse req=01 -> gnt=01 one cycle later. Owner writes 3 pixels at (row 2, col 5..7) -> m_wen and addresses match. Pulse done -> gnt=00. frame_complete -> mem_flip=1, frame_count=1.
- req=11 from IDLE after reset -> gnt=01. After its flip, with req=11 still held -> gnt=10 (round-robin).
- While requester 0 owns, requester 1 drives wen_i=1 at row 7 -> m_wen follows only requester 0 and row 7 is never written.
- done and frame_complete in the same cycle -> no flip. The next frame_complete 256 cycles later -> mem_flip toggles.
- Owner drops req mid-frame -> IDLE, gnt=00, mem_flip unchanged, frame_count unchanged.
- ARB_TIMEOUT_EN with timeout_cycles=16: owner writes once then stalls -> timeout pulses exactly 16 cycles after the last write, gnt=00, no flip. Also assert rst during PEND -> mem_flip=0 and frame_count=0 next cycle.
